// File: rtl/csr_defines.sv
// rtl/csr_defines.sv - shared CSR addresses, field positions and helpers
//
// Purpose: constants and types used by excp_csr_commit and excp_csr_rmux.
// Ports: none (package).
package csr_defines;

  // CSR address map
  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECFG      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00C;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h088;
  localparam logic [13:0] CSR_TLBRERA   = 14'h08A;

  // Exception codes
  localparam logic [5:0] ECODE_SYS          = 6'h0B;
  localparam logic [5:0] ECODE_TLBR_DEFAULT = 6'h3F;

  // Field bit positions (LSB of multi-bit fields)
  localparam int CRMD_PLV       = 0;
  localparam int CRMD_IE        = 2;
  localparam int CRMD_DA        = 3;
  localparam int CRMD_PG        = 4;
  localparam int PRMD_PPLV      = 0;
  localparam int PRMD_PIE       = 2;
  localparam int ESTAT_IS       = 0;
  localparam int ESTAT_ECODE    = 16;
  localparam int ESTAT_ESUBCODE = 22;
  localparam int TLBRERA_ISTLBR = 0;

  typedef struct packed {
    logic       pg;
    logic       da;
    logic       ie;
    logic [1:0] plv;
  } crmd_t;

  // Masked CSR write: bits selected by wmask take wdata, the rest keep old_val.
  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [31:0] wmask);
    return (old_val & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/excp_csr_rmux.sv
// rtl/excp_csr_rmux.sv - CSR read-address decoder and data mux
//
// Purpose: selects one 32-bit CSR view by address; 0 for unimplemented addresses.
// Ports:
//   raddr                  in  14  CSR address
//   crmd..tlbrera          in  32  full-width CSR views (reserved bits already 0)
//   rdata                  out 32  selected CSR value
module excp_csr_rmux
  import csr_defines::*;
(
  input  logic [13:0] raddr,
  input  logic [31:0] crmd,
  input  logic [31:0] prmd,
  input  logic [31:0] ecfg,
  input  logic [31:0] estat,
  input  logic [31:0] era,
  input  logic [31:0] badv,
  input  logic [31:0] eentry,
  input  logic [31:0] tlbrentry,
  input  logic [31:0] tlbrera,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = 32'h0;
    case (raddr)
      CSR_CRMD:      rdata = crmd;
      CSR_PRMD:      rdata = prmd;
      CSR_ECFG:      rdata = ecfg;
      CSR_ESTAT:     rdata = estat;
      CSR_ERA:       rdata = era;
      CSR_BADV:      rdata = badv;
      CSR_EENTRY:    rdata = eentry;
      CSR_TLBRENTRY: rdata = tlbrentry;
      CSR_TLBRERA:   rdata = tlbrera;
      default:       rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/excp_csr_commit.sv
// rtl/excp_csr_commit.sv - exception/ertn commit CSR block with fetch redirect
//
// Purpose: applies writeback exception entry / ertn to CRMD, PRMD, ESTAT, ERA,
// BADV, TLBRERA; owns ECFG, EENTRY, TLBRENTRY; CSR read/write port; registered
// redirect pulse and interrupt-pending flag.
// Ports:
//   clk, reset (sync, active-low)
//   excp_flush, ertn_flush            commit strobes (excp wins when both high)
//   excp_era, ecode, esubcode         exception PC and cause
//   badv, badv_valid                  faulting address and its update enable
//   excp_tlb, excp_tlbrefill          TLB-class / TLB-refill exception flags
//   hw_int                            level hardware interrupts -> ESTAT.IS[9:2]
//   csr_we, csr_waddr, csr_wdata, csr_wmask   masked CSR write
//   csr_raddr, csr_rdata              combinational CSR read (pre-update state)
//   redirect_valid, redirect_pc       registered one-cycle redirect to fetch
//   crmd_plv, crmd_da, crmd_pg        current mode bits
//   int_pending                       registered interrupt request
module excp_csr_commit
  import csr_defines::*;
#(
  parameter int          HW_INT_W   = 8,
  parameter logic [5:0]  ECODE_TLBR = ECODE_TLBR_DEFAULT,
  parameter int          ENTRY_LSB  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                excp_flush,
  input  logic                ertn_flush,
  input  logic [31:0]         excp_era,
  input  logic [5:0]          ecode,
  input  logic [8:0]          esubcode,
  input  logic [31:0]         badv,
  input  logic                badv_valid,
  input  logic                excp_tlb,
  input  logic                excp_tlbrefill,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                csr_we,
  input  logic [13:0]         csr_waddr,
  input  logic [31:0]         csr_wdata,
  input  logic [31:0]         csr_wmask,
  input  logic [13:0]         csr_raddr,
  output logic [31:0]         csr_rdata,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic [1:0]          crmd_plv,
  output logic                crmd_da,
  output logic                crmd_pg,
  output logic                int_pending
);

  // Architectural state
  crmd_t                 crmd;
  logic [2:0]            prmd;
  logic [12:0]           ecfg_lie;
  logic [1:0]            estat_is_sw;
  logic [HW_INT_W-1:0]   estat_is_hw;
  logic [5:0]            estat_ecode;
  logic [8:0]            estat_esubcode;
  logic [31:0]           era;
  logic [31:0]           badv_q;
  logic [31:ENTRY_LSB]   eentry;
  logic [31:ENTRY_LSB]   tlbrentry;
  logic [31:2]           tlbrera_pc;
  logic                  tlbrera_istlbr;

  // Full-width views
  logic [12:0] estat_is;
  logic [31:0] crmd_v, prmd_v, ecfg_v, estat_v, eentry_v, tlbrentry_v, tlbrera_v;
  logic [31:0] wr_old, wr_merged, target;

  // excp_tlb is only carried for a future TLBEHI; ECODE_TLBR is informational
  // since refill is signalled explicitly by excp_tlbrefill.
  logic unused_ok;
  assign unused_ok = &{1'b0, excp_tlb, (ecode == ECODE_TLBR)};

  assign estat_is = 13'({estat_is_hw, estat_is_sw});

  always_comb begin
    crmd_v                       = 32'h0;
    crmd_v[CRMD_PLV +: 2]        = crmd.plv;
    crmd_v[CRMD_IE]              = crmd.ie;
    crmd_v[CRMD_DA]              = crmd.da;
    crmd_v[CRMD_PG]              = crmd.pg;
    prmd_v                       = 32'h0;
    prmd_v[2:0]                  = prmd;
    ecfg_v                       = 32'h0;
    ecfg_v[12:0]                 = ecfg_lie;
    estat_v                      = 32'h0;
    estat_v[ESTAT_IS +: 13]      = estat_is;
    estat_v[ESTAT_ECODE +: 6]    = estat_ecode;
    estat_v[ESTAT_ESUBCODE +: 9] = estat_esubcode;
    tlbrera_v                    = 32'h0;
    tlbrera_v[31:2]              = tlbrera_pc;
    tlbrera_v[TLBRERA_ISTLBR]    = tlbrera_istlbr;
  end

  assign eentry_v    = {eentry, {ENTRY_LSB{1'b0}}};
  assign tlbrentry_v = {tlbrentry, {ENTRY_LSB{1'b0}}};

  excp_csr_rmux u_rmux_rd (
    .raddr     (csr_raddr),
    .crmd      (crmd_v),
    .prmd      (prmd_v),
    .ecfg      (ecfg_v),
    .estat     (estat_v),
    .era       (era),
    .badv      (badv_q),
    .eentry    (eentry_v),
    .tlbrentry (tlbrentry_v),
    .tlbrera   (tlbrera_v),
    .rdata     (csr_rdata)
  );

  // Second decoder fetches the current value at the write address so the
  // masked merge works on the whole word before writable fields are picked.
  excp_csr_rmux u_rmux_wr (
    .raddr     (csr_waddr),
    .crmd      (crmd_v),
    .prmd      (prmd_v),
    .ecfg      (ecfg_v),
    .estat     (estat_v),
    .era       (era),
    .badv      (badv_q),
    .eentry    (eentry_v),
    .tlbrentry (tlbrentry_v),
    .tlbrera   (tlbrera_v),
    .rdata     (wr_old)
  );

  assign wr_merged = csr_merge(wr_old, csr_wdata, csr_wmask);

  // Redirect target; excp_flush takes priority over ertn_flush.
  always_comb begin
    if (excp_flush) begin
      target = excp_tlbrefill ? tlbrentry_v : eentry_v;
    end else if (tlbrera_istlbr) begin
      target = {tlbrera_pc, 2'b00};
    end else begin
      target = era;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      crmd           <= '{pg: 1'b0, da: 1'b1, ie: 1'b0, plv: 2'd0};
      prmd           <= '0;
      ecfg_lie       <= '0;
      estat_is_sw    <= '0;
      estat_is_hw    <= '0;
      estat_ecode    <= '0;
      estat_esubcode <= '0;
      era            <= '0;
      badv_q         <= '0;
      eentry         <= '0;
      tlbrentry      <= '0;
      tlbrera_pc     <= '0;
      tlbrera_istlbr <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      int_pending    <= 1'b0;
    end else begin
      estat_is_hw    <= hw_int;
      int_pending    <= (|(estat_is & ecfg_lie)) & crmd.ie;
      redirect_valid <= excp_flush | ertn_flush;
      if (excp_flush | ertn_flush) begin
        redirect_pc <= target;
      end

      if (excp_flush) begin
        prmd[PRMD_PPLV +: 2] <= crmd.plv;
        prmd[PRMD_PIE]       <= crmd.ie;
        crmd.plv             <= 2'd0;
        crmd.ie              <= 1'b0;
        estat_ecode          <= ecode;
        estat_esubcode       <= esubcode;
        if (badv_valid) begin
          badv_q <= badv;
        end
        if (excp_tlbrefill) begin
          tlbrera_pc     <= excp_era[31:2];
          tlbrera_istlbr <= 1'b1;
          crmd.da        <= 1'b1;
          crmd.pg        <= 1'b0;
        end else begin
          era <= excp_era;
        end
      end else if (ertn_flush) begin
        crmd.plv <= prmd[PRMD_PPLV +: 2];
        crmd.ie  <= prmd[PRMD_PIE];
        if (tlbrera_istlbr) begin
          crmd.da        <= 1'b0;
          crmd.pg        <= 1'b1;
          tlbrera_istlbr <= 1'b0;
        end
      end else if (csr_we) begin
        case (csr_waddr)
          CSR_CRMD: begin
            crmd.plv <= wr_merged[CRMD_PLV +: 2];
            crmd.ie  <= wr_merged[CRMD_IE];
            crmd.da  <= wr_merged[CRMD_DA];
            crmd.pg  <= wr_merged[CRMD_PG];
          end
          CSR_PRMD:      prmd        <= wr_merged[2:0];
          CSR_ECFG:      ecfg_lie    <= wr_merged[12:0];
          CSR_ESTAT:     estat_is_sw <= wr_merged[ESTAT_IS +: 2];
          CSR_ERA:       era         <= wr_merged;
          CSR_BADV:      badv_q      <= wr_merged;
          CSR_EENTRY:    eentry      <= wr_merged[31:ENTRY_LSB];
          CSR_TLBRENTRY: tlbrentry   <= wr_merged[31:ENTRY_LSB];
          CSR_TLBRERA: begin
            tlbrera_pc     <= wr_merged[31:2];
            tlbrera_istlbr <= wr_merged[TLBRERA_ISTLBR];
          end
          default: ;
        endcase
      end
    end
  end

  assign crmd_plv = crmd.plv;
  assign crmd_da  = crmd.da;
  assign crmd_pg  = crmd.pg;

endmodule

// File: tb/tb_excp_csr_commit.sv
// tb/tb_excp_csr_commit.sv - self-checking bench for excp_csr_commit
module tb_excp_csr_commit;
  import csr_defines::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        excp_flush, ertn_flush;
  logic [31:0] excp_era;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] badv;
  logic        badv_valid, excp_tlb, excp_tlbrefill;
  logic [7:0]  hw_int;
  logic        csr_we;
  logic [13:0] csr_waddr, csr_raddr;
  logic [31:0] csr_wdata, csr_wmask;
  logic [31:0] csr_rdata, redirect_pc;
  logic        redirect_valid, crmd_da, crmd_pg, int_pending;
  logic [1:0]  crmd_plv;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: whole-word CSR image indexed by address low byte.
  logic [31:0] m [0:255];
  logic        m_rv, m_ip;
  logic [31:0] m_pc;

  logic [13:0] addr_tab [13];

  always #5 clk = ~clk;

  excp_csr_commit dut (
    .clk(clk), .reset(reset), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .excp_era(excp_era), .ecode(ecode), .esubcode(esubcode), .badv(badv),
    .badv_valid(badv_valid), .excp_tlb(excp_tlb), .excp_tlbrefill(excp_tlbrefill),
    .hw_int(hw_int), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_wmask(csr_wmask), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .crmd_plv(crmd_plv),
    .crmd_da(crmd_da), .crmd_pg(crmd_pg), .int_pending(int_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Writable-bit mask per CSR address; addresses outside the map give 0.
  function automatic logic [31:0] wr_mask(input logic [13:0] a);
    case (a)
      14'h000: return 32'h0000_001F;
      14'h001: return 32'h0000_0007;
      14'h004: return 32'h0000_1FFF;
      14'h005: return 32'h0000_0003;
      14'h006: return 32'hFFFF_FFFF;
      14'h007: return 32'hFFFF_FFFF;
      14'h00C: return 32'hFFFF_FFC0;
      14'h088: return 32'hFFFF_FFC0;
      14'h08A: return 32'hFFFF_FFFD;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    return (wr_mask(a) != 0) ? m[a[7:0]] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m[i] = 32'h0;
    m[0] = 32'h8;
    m_rv = 1'b0;
    m_pc = 32'h0;
    m_ip = 1'b0;
  endtask

  task automatic model_clock();
    logic [31:0] n [0:255];
    logic [31:0] crmd, tgt, msk;
    logic        fire;
    if (!reset) begin
      model_reset();
      return;
    end
    n    = m;
    m_ip = (|(m[5][12:0] & m[4][12:0])) & m[0][2];
    n[5] = (m[5] & ~32'h3FC) | ({24'b0, hw_int} << 2);
    crmd = m[0];
    tgt  = m_pc;
    fire = 1'b1;
    if (excp_flush) begin
      n[1] = crmd & 32'h7;
      crmd = crmd & ~32'h7;
      n[5] = (n[5] & 32'h8000_FFFF) | ({23'b0, esubcode} << 22) | ({26'b0, ecode} << 16);
      if (badv_valid) n[7] = badv;
      if (excp_tlbrefill) begin
        n[8'h8A] = {excp_era[31:2], 2'b01};
        crmd     = (crmd | 32'h8) & ~32'h10;
        tgt      = m[8'h88];
      end else begin
        n[6] = excp_era;
        tgt  = m[8'h0C];
      end
    end else if (ertn_flush) begin
      crmd = (crmd & ~32'h7) | (m[1] & 32'h7);
      if (m[8'h8A][0]) begin
        crmd     = (crmd & ~32'h8) | 32'h10;
        n[8'h8A] = m[8'h8A] & ~32'h1;
        tgt      = m[8'h8A] & ~32'h3;
      end else begin
        tgt = m[6];
      end
    end else begin
      fire = 1'b0;
      if (csr_we) begin
        msk = csr_wmask & wr_mask(csr_waddr);
        if (msk != 0)
          n[csr_waddr[7:0]] = (n[csr_waddr[7:0]] & ~msk) | (csr_wdata & msk);
      end
    end
    if (fire) n[0] = crmd;
    m_rv = fire;
    if (fire) m_pc = tgt;
    m = n;
  endtask

  // One clock: check pre-edge read, advance model, check registered outputs.
  task automatic step();
    #1;
    check("rdata", csr_rdata, m_read(csr_raddr));
    model_clock();
    @(posedge clk);
    #1;
    check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
    check("redirect_pc", redirect_pc, m_pc);
    check("int_pending", {31'b0, int_pending}, {31'b0, m_ip});
    check("crmd_bits", {28'b0, crmd_pg, crmd_da, crmd_plv}, {28'b0, m[0][4:3], m[0][1:0]});
  endtask

  task automatic rd_check(input string tag, input logic [13:0] a, input logic [31:0] exp);
    csr_raddr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic idle();
    excp_flush = 0; ertn_flush = 0; excp_tlbrefill = 0; excp_tlb = 0;
    badv_valid = 0; csr_we = 0; csr_wmask = 32'hFFFF_FFFF;
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d, input logic [31:0] mk);
    idle();
    csr_we = 1; csr_waddr = a; csr_wdata = d; csr_wmask = mk;
    step();
    idle();
  endtask

  initial begin
    addr_tab = '{CSR_CRMD, CSR_PRMD, CSR_ECFG, CSR_ESTAT, CSR_ERA, CSR_BADV, CSR_EENTRY,
                 CSR_TLBRENTRY, CSR_TLBRERA, 14'h002, 14'h008, 14'h089, 14'h3FFF};
    idle();
    excp_era = 0; ecode = 0; esubcode = 0; badv = 0; hw_int = 0;
    csr_waddr = 0; csr_wdata = 0; csr_raddr = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_rv", {31'b0, redirect_valid}, 32'h0);
    check("reset_ip", {31'b0, int_pending}, 32'h0);
    rd_check("reset_crmd", CSR_CRMD, 32'h8);
    reset = 1;

    // Plain exception and return
    csr_write(CSR_EENTRY, 32'h1C00_8000, 32'hFFFF_FFFF);
    csr_write(CSR_CRMD, 32'h7, 32'h7);
    excp_flush = 1; ecode = ECODE_SYS; esubcode = 0; excp_era = 32'h1C00_0100;
    step(); idle();
    check("sys_rv", {31'b0, redirect_valid}, 32'h1);
    check("sys_pc", redirect_pc, 32'h1C00_8000);
    rd_check("sys_era", CSR_ERA, 32'h1C00_0100);
    rd_check("sys_prmd", CSR_PRMD, 32'h7);
    rd_check("sys_crmd", CSR_CRMD, 32'h8);
    csr_raddr = CSR_ESTAT;
    #1;
    check("sys_ecode", {26'b0, csr_rdata[21:16]}, 32'h0B);
    ertn_flush = 1;
    step(); idle();
    check("ertn_pc", redirect_pc, 32'h1C00_0100);
    check("ertn_plv", {30'b0, crmd_plv}, 32'h3);
    rd_check("ertn_crmd", CSR_CRMD, 32'hF);

    // TLB refill and return
    csr_write(CSR_TLBRENTRY, 32'h1C00_F03F, 32'hFFFF_FFFF);
    rd_check("tlbrentry_align", CSR_TLBRENTRY, 32'h1C00_F000);
    excp_flush = 1; excp_tlbrefill = 1; badv_valid = 1; badv = 32'hDEAD_0000;
    excp_era = 32'h1C00_0200;
    step(); idle();
    check("tlbr_pc", redirect_pc, 32'h1C00_F000);
    check("tlbr_dapg", {30'b0, crmd_da, crmd_pg}, 32'h2);
    rd_check("tlbr_tlbrera", CSR_TLBRERA, 32'h1C00_0201);
    rd_check("tlbr_badv", CSR_BADV, 32'hDEAD_0000);
    ertn_flush = 1;
    step(); idle();
    check("tlbr_ertn_pc", redirect_pc, 32'h1C00_0200);
    check("tlbr_ertn_dapg", {30'b0, crmd_da, crmd_pg}, 32'h1);
    rd_check("tlbr_ertn_tlbrera", CSR_TLBRERA, 32'h1C00_0200);

    // Interrupt pending pipeline
    csr_write(CSR_ECFG, 32'h004, 32'hFFFF_FFFF);
    csr_write(CSR_CRMD, 32'h4, 32'h4);
    hw_int = 8'h01;
    step();
    check("ip_first", {31'b0, int_pending}, 32'h0);
    step();
    check("ip_second", {31'b0, int_pending}, 32'h1);
    excp_flush = 1; excp_era = 32'h1C00_0400;
    step(); idle();
    check("ip_after_flush", {31'b0, int_pending}, 32'h1);
    step();
    check("ip_cleared", {31'b0, int_pending}, 32'h0);
    hw_int = 8'h00;

    // CSR write collides with flush
    excp_flush = 1; excp_era = 32'h100;
    csr_we = 1; csr_waddr = CSR_ERA; csr_wdata = 32'hFFFF_0000;
    step(); idle();
    rd_check("collide_era", CSR_ERA, 32'h100);

    // Back-to-back flushes
    excp_flush = 1; excp_era = 32'h1C00_0300;
    step(); idle();
    check("b2b_rv1", {31'b0, redirect_valid}, 32'h1);
    check("b2b_pc1", redirect_pc, 32'h1C00_8000);
    ertn_flush = 1;
    step(); idle();
    check("b2b_rv2", {31'b0, redirect_valid}, 32'h1);
    check("b2b_pc2", redirect_pc, 32'h1C00_0300);
    step();
    check("b2b_rv3", {31'b0, redirect_valid}, 32'h0);

    // Reset in the middle of a redirect
    excp_flush = 1;
    step(); idle();
    reset = 0;
    step();
    check("rst_mid_rv", {31'b0, redirect_valid}, 32'h0);
    reset = 1;

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      int r;
      idle();
      r = int'($urandom_range(0, 99));
      reset = ($urandom_range(0, 199) != 0);
      if (r < 12) excp_flush = 1;
      else if (r < 22) ertn_flush = 1;
      else if (r < 25) begin excp_flush = 1; ertn_flush = 1; end
      excp_tlbrefill = ($urandom_range(0, 2) == 0);
      excp_tlb       = excp_tlbrefill | ($urandom_range(0, 3) == 0);
      badv_valid     = 1'($urandom_range(0, 1));
      ecode          = 6'($urandom);
      esubcode       = 9'($urandom);
      excp_era       = $urandom;
      badv           = $urandom;
      csr_we         = 1'($urandom_range(0, 1));
      csr_waddr      = addr_tab[$urandom_range(0, 12)];
      csr_wdata      = $urandom;
      csr_wmask      = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
      csr_raddr      = addr_tab[$urandom_range(0, 12)];
      if ($urandom_range(0, 7) == 0) hw_int = 8'($urandom);
      step();
    end
    reset = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/excp_csr_commit.md
Name: excp_csr_commit

Overview:
- Receiving end of the writeback exception/ertn commit interface; LoongArch CSR side of exception entry and return.
- Consumes flush, ecode, badv and era from writeback and updates CRMD, PRMD, ESTAT, ERA, BADV and TLBRERA.
- Issues one registered redirect pulse to the fetch stage.
- Also owns ECFG, EENTRY and TLBRENTRY; provides the CSR read/write port and a registered interrupt-pending signal back to writeback.

Parameters:
- HW_INT_W, 8, number of hardware interrupt lines (ESTAT.IS[9:2]).
- ECODE_TLBR, 6'h3F, ecode value marking TLB refill.
- ENTRY_LSB, 6, low bits of EENTRY and TLBRENTRY forced to zero (64-byte alignment).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- excp_flush  in  1  exception commit, already gated by valid and icache_busy
- ertn_flush  in  1  ertn commit
- excp_era  in  32  PC of the committing instruction
- ecode  in  6  exception code
- esubcode  in  9  exception subcode
- badv  in  32  faulting address
- badv_valid  in  1  BADV update enable
- excp_tlb  in  1  TLB-class exception (no action in this block beyond sampling; reserved for TLBEHI)
- excp_tlbrefill  in  1  TLB refill exception
- hw_int  in  HW_INT_W  level interrupt inputs
- csr_we  in  1  CSR write enable
- csr_waddr  in  14  CSR write address
- csr_wdata  in  32  write data
- csr_wmask  in  32  per-bit write mask
- csr_raddr  in  14  CSR read address
- csr_rdata  out  32  combinational read data; 0 for unimplemented addresses
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  redirect target
- crmd_plv  out  2  current privilege level
- crmd_da  out  1  direct-address mode
- crmd_pg  out  1  paging mode
- int_pending  out  1  registered interrupt request to writeback

Behaviour:
- Address map: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, TLBRENTRY 0x88, TLBRERA 0x8A.
- Reset (reset==0 at posedge):
  - CRMD = 0x8 (DA=1, PG=0, PLV=0, IE=0); all other CSRs = 0.
  - redirect_valid = 0, redirect_pc = 0, int_pending = 0.
- Priority per cycle: excp_flush > ertn_flush > csr_we.
  - csr_we is ignored in any cycle where either flush is high.
  - Both flushes high together: treat as excp_flush only.
- excp_flush at cycle N, applied at posedge closing N:
  - PRMD.PPLV,PIE <= CRMD.PLV,IE; CRMD.PLV <= 0; CRMD.IE <= 0.
  - ESTAT.Ecode <= ecode; ESTAT.EsubCode <= esubcode.
  - If badv_valid: BADV <= badv.
  - If excp_tlbrefill:
    - TLBRERA.PC[31:2] <= excp_era[31:2]; TLBRERA.IsTLBR <= 1.
    - CRMD.DA <= 1; CRMD.PG <= 0.
    - Target = TLBRENTRY.
  - Otherwise: ERA <= excp_era; target = EENTRY.
- ertn_flush at cycle N:
  - CRMD.PLV,IE <= PRMD.PPLV,PIE.
  - If TLBRERA.IsTLBR:
    - CRMD.DA <= 0; CRMD.PG <= 1; IsTLBR <= 0.
    - Target = {TLBRERA.PC, 2'b0}.
  - Otherwise: target = ERA.
- Redirect latency:
  - redirect_valid = 1 in cycle N+1 for exactly one cycle; redirect_pc holds the target computed in N.
  - redirect_pc holds its last value otherwise.
  - A flush arriving in N+1 produces a fresh pulse in N+2; no flush is dropped.
- ESTAT.IS:
  - IS[9:2] is sampled from hw_int every cycle (one-cycle register).
  - IS[1:0] is software-writable through csr_we.
  - All other ESTAT bits are read-only to csr_we.
- int_pending: registered each cycle as |(ESTAT.IS[12:0] & ECFG.LIE[12:0]) & CRMD.IE. It is cleared in the cycle after excp_flush because IE drops.
- CSR writes: reg <= (reg & ~csr_wmask) | (csr_wdata & csr_wmask), restricted to writable fields.
  - EENTRY and TLBRENTRY low ENTRY_LSB bits stay 0.
  - Writes to unimplemented addresses have no effect.
- csr_rdata reflects state before the current cycle's update; there is no write-to-read forwarding.
- Reset asserted mid-redirect: redirect_valid is 0 in the next cycle.

Decomposition:
- Shared package (csr_defines): CSR address constants, ECODE_* values, field bit positions (CRMD_PLV, CRMD_IE, CRMD_DA, CRMD_PG, PRMD_PPLV, PRMD_PIE, ESTAT_IS, ESTAT_ECODE, ESTAT_ESUBCODE, TLBRERA_ISTLBR).
- One sub-module, excp_csr_rmux: a combinational read-address decoder and mux for csr_rdata.
- All state lives in the top module.

Test Plan:
- Reset, then read CRMD -> 0x00000008; redirect_valid=0; int_pending=0.
- Set EENTRY=0x1C008000 and CRMD PLV=3, IE=1. Pulse excp_flush with ecode=0x0B (SYS), excp_era=0x1C000100 -> next cycle redirect_valid=1, redirect_pc=0x1C008000; ERA=0x1C000100; PRMD=0x7; CRMD.PLV=0, IE=0; ESTAT[21:16]=0x0B.
- Following that, pulse ertn_flush -> redirect_pc=0x1C000100; CRMD.PLV=3, IE=1.
- Set TLBRENTRY=0x1C00F000. Pulse excp_flush with excp_tlbrefill=1, badv_valid=1, badv=0xDEAD0000, excp_era=0x1C000200 -> redirect_pc=0x1C00F000; TLBRERA=0x1C000201; BADV=0xDEAD0000; DA=1, PG=0. Then pulse ertn_flush -> redirect_pc=0x1C000200; DA=0, PG=1; IsTLBR=0.
- With ECFG.LIE=0x004, CRMD.IE=1, raise hw_int[0] -> int_pending=1 two cycles later. Then excp_flush -> int_pending=0 the cycle after IE clears.
- csr_we to ERA together with excp_flush (era=0x100) -> ERA=0x100 and the write is discarded. Back-to-back flushes in N and N+1 -> pulses in N+1 and N+2, each with the correct target.
